// File: rtl/la_scanctrl_pkg.sv
// Shared types for the scan test controller.
// State encoding and counter sizing helper.
package la_scan_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/la_scanctrl_if.sv
// Pattern handshake bundle for the scan controller.
// Stimulus and expected vector travel with pat_valid.
interface la_scanctrl_if #(
  parameter int N = 8
);
  logic         pat_valid;
  logic [N-1:0] pat_in;
  logic [N-1:0] exp_in;
  logic         pat_ready;

  modport master (
    output pat_valid,
    output pat_in,
    output exp_in,
    input  pat_ready
  );

  modport slave (
    input  pat_valid,
    input  pat_in,
    input  exp_in,
    output pat_ready
  );
endinterface

// File: rtl/la_scanshift.sv
// Pattern shift-out register and expected-vector compare.
// exp_q rotates so it is realigned after the load pass.
module la_scanshift #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] pat_in,
  input  logic [N-1:0] exp_in,
  input  logic         so,
  output logic         sout,
  output logic         mismatch
);
  logic [N-1:0] pat_q;
  logic [N-1:0] exp_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pat_q <= '0;
      exp_q <= '0;
    end else if (load) begin
      pat_q <= pat_in;
      exp_q <= exp_in;
    end else if (shift) begin
      pat_q <= {1'b0, pat_q[N-1:1]};
      exp_q <= {exp_q[0], exp_q[N-1:1]};
    end
  end

  // pat_q drains to zero during load, so si idles low
  assign sout     = pat_q[0];
  assign mismatch = so ^ exp_q[0];

endmodule

// File: rtl/la_scanctrl.sv
// Scan test controller: load, capture, unload, compare.
// Drives chain se/si and accumulates unload mismatches.
module la_scanctrl
  import la_scan_pkg::*;
#(
  parameter int N   = 8,
  parameter int CAP = 1,
  parameter int EW  = 8
) (
  input  logic          clk,
  input  logic          nreset,
  la_scanctrl_if.slave  pat,
  input  logic          clear,
  output logic          se,
  output logic          si,
  input  logic          so,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [EW-1:0] err_count
);
  localparam int IW = cnt_w(N);
  localparam int CW = cnt_w(CAP + 1);

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic [CW-1:0] cap;
  logic [CW-1:0] cap_n;
  logic          load;
  logic          shift;
  logic          mism;
  logic          inc;

  la_scanshift #(
    .N(N)
  ) u_shift (
    .clk      (clk),
    .nreset   (nreset),
    .load     (load),
    .shift    (shift),
    .pat_in   (pat.pat_in),
    .exp_in   (pat.exp_in),
    .so       (so),
    .sout     (si),
    .mismatch (mism)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cap_n   = cap;
    load    = 1'b0;
    shift   = 1'b0;
    inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pat.pat_valid) begin
          load    = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        shift = 1'b1;
        if (idx == IW'(N - 1)) begin
          idx_n   = '0;
          state_n = CAPTURE;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      CAPTURE: begin
        if (cap == CW'(CAP - 1)) begin
          cap_n   = '0;
          state_n = UNLOAD;
        end else begin
          cap_n = cap + 1'b1;
        end
      end
      UNLOAD: begin
        shift = 1'b1;
        inc   = mism;
        if (idx == IW'(N - 1)) begin
          idx_n   = '0;
          state_n = DONE;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      idx   <= '0;
      cap   <= '0;
      se    <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cap   <= cap_n;
      se    <= (state_n == LOAD) ||
               (state_n == UNLOAD);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fail      <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      fail      <= 1'b0;
      err_count <= '0;
    end else if (inc) begin
      fail <= 1'b1;
      if (err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

  assign pat.pat_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

endmodule
